sort_step_controller: RTL and testbench

Sequencer for the bar-sorting visualisation. It runs an early-terminating bubble sort over an external bar register file one compare-swap at a time through a request/response handshake, and paces each step with a programmable delay. It supports pause, single-step and abort, and exports the current pass and compare indices to the OLED renderer for highlight colouring.

---
 rtl/sort_step_controller.sv | 151 +++++++++++++++
 tb/tb_sort_step_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_step_controller.sv
// Paced bubble-sort sequencer: issues one compare-swap request at a time to an
// external bar register file and ends early once a pass makes no swaps.
module sort_step_controller #(
  parameter int N_BARS     = 5,
  parameter int IDX_W      = 3,
  parameter int BASE_DELAY = 50000000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             step,
  input  logic [1:0]       speed,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic [IDX_W-1:0] cmp_idx,
  input  logic             resp_valid,
  input  logic             resp_swapped,
  output logic [IDX_W-1:0] pass_idx,
  output logic             busy,
  output logic             sorted,
  output logic             done,
  output logic [CNT_W-1:0] swap_count
);

  localparam int DLY_W = $clog2(BASE_DELAY + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_PASS_END = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N_BARS - 2);
  localparam logic [DLY_W-1:0] BASE_DLY  = DLY_W'(BASE_DELAY);

  logic [2:0]       state;
  logic [DLY_W-1:0] delay_cnt;
  logic [DLY_W-1:0] shifted;
  logic [DLY_W-1:0] target;
  logic             pass_swapped;
  logic [IDX_W-1:0] last_cmp;

  // Speed-scaled delay target; large speeds can shift it to zero, so floor it at one cycle.
  always_comb begin
    shifted = BASE_DLY >> {speed, 1'b0};
    if (shifted == '0) begin
      target = DLY_W'(1);
    end else begin
      target = shifted;
    end
    last_cmp = LAST_PASS - pass_idx;
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      delay_cnt    <= '0;
      pass_swapped <= 1'b0;
      cmp_valid    <= 1'b0;
      cmp_idx      <= '0;
      pass_idx     <= '0;
      busy         <= 1'b0;
      sorted       <= 1'b0;
      done         <= 1'b0;
      swap_count   <= '0;
    end else if (abort) begin
      // Indices and swap count are left visible for the renderer after an abort.
      state     <= S_IDLE;
      delay_cnt <= '0;
      cmp_valid <= 1'b0;
      busy      <= 1'b0;
      sorted    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass_idx     <= '0;
            cmp_idx      <= '0;
            swap_count   <= '0;
            pass_swapped <= 1'b0;
            delay_cnt    <= '0;
            sorted       <= 1'b0;
            busy         <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pause) begin
            if (step) begin
              delay_cnt <= '0;
              cmp_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          end else if (delay_cnt >= target - DLY_W'(1)) begin
            delay_cnt <= '0;
            cmp_valid <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            delay_cnt <= delay_cnt + DLY_W'(1);
          end
        end
        S_ISSUE: begin
          if (cmp_ready) begin
            cmp_valid <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_valid) begin
            if (resp_swapped && (swap_count != '1)) begin
              swap_count <= swap_count + CNT_W'(1);
            end
            pass_swapped <= pass_swapped | resp_swapped;
            if (cmp_idx == last_cmp) begin
              state <= S_PASS_END;
            end else begin
              cmp_idx <= cmp_idx + IDX_W'(1);
              state   <= S_WAIT;
            end
          end
        end
        S_PASS_END: begin
          if ((pass_idx == LAST_PASS) || !pass_swapped) begin
            busy   <= 1'b0;
            sorted <= 1'b1;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            pass_idx     <= pass_idx + IDX_W'(1);
            cmp_idx      <= '0;
            pass_swapped <= 1'b0;
            state        <= S_WAIT;
          end
        end
        default: begin
          cmp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_step_controller.sv
// Directed bench for sort_step_controller: a 5-entry bar file model answers
// each compare request and the sequence of requests is checked against hand values.
module tb_sort_step_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       cmp_valid;
  logic       cmp_ready;
  logic [2:0] cmp_idx;
  logic       resp_valid = 1'b0;
  logic       resp_swapped = 1'b0;
  logic [2:0] pass_idx;
  logic       busy;
  logic       sorted;
  logic       done;
  logic [7:0] swap_count;

  logic ready_block = 1'b0;
  int   resp_delay = 0;
  int   arr [5];
  int   load_val [5];
  logic load_go = 1'b0;
  int   hs_count = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   hs_log [$];
  int   hs_cyc [$];
  logic pend = 1'b0;
  int   pend_wait = 0;
  logic pend_swap = 1'b0;
  int   checks = 0;
  int   errors = 0;

  assign cmp_ready = !ready_block;

  always #5 clk = ~clk;

  sort_step_controller #(
    .N_BARS(5), .IDX_W(3), .BASE_DELAY(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .step(step), .speed(speed), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_idx(cmp_idx), .resp_valid(resp_valid), .resp_swapped(resp_swapped),
    .pass_idx(pass_idx), .busy(busy), .sorted(sorted), .done(done),
    .swap_count(swap_count)
  );

  // Bar file model: swaps on handshake, answers resp_delay cycles after the normal slot.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    resp_valid   <= 1'b0;
    resp_swapped <= 1'b0;
    if (done) done_cnt <= done_cnt + 1;
    if (reset) begin
      pend <= 1'b0;
    end else if (load_go) begin
      for (int i = 0; i < 5; i++) arr[i] <= load_val[i];
      pend <= 1'b0;
    end else if (pend) begin
      if (pend_wait == 0) begin
        resp_valid   <= 1'b1;
        resp_swapped <= pend_swap;
        pend         <= 1'b0;
      end else begin
        pend_wait <= pend_wait - 1;
      end
    end else if (cmp_valid && cmp_ready) begin
      hs_count <= hs_count + 1;
      hs_log.push_back(int'(cmp_idx));
      hs_cyc.push_back(cyc);
      if (arr[int'(cmp_idx)] > arr[int'(cmp_idx) + 1]) begin
        arr[int'(cmp_idx)]     <= arr[int'(cmp_idx) + 1];
        arr[int'(cmp_idx) + 1] <= arr[int'(cmp_idx)];
      end
      if (resp_delay == 0) begin
        resp_valid   <= 1'b1;
        resp_swapped <= (arr[int'(cmp_idx)] > arr[int'(cmp_idx) + 1]);
      end else begin
        pend      <= 1'b1;
        pend_wait <= resp_delay - 1;
        pend_swap <= (arr[int'(cmp_idx)] > arr[int'(cmp_idx) + 1]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3, input int a4);
    load_val[0] = a0; load_val[1] = a1; load_val[2] = a2; load_val[3] = a3; load_val[4] = a4;
    load_go = 1'b1;
    tick(1);
    load_go = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_hs(input string tag, input int target);
    int n = 0;
    while (hs_count < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(hs_count), 32'(target));
  endtask

  initial begin
    int base;
    int dbase;
    int n;
    int exp_seq [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    logic seen;

    // Reset state.
    tick(3);
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("rst_cmp_idx", 32'(cmp_idx), 32'd0);
    check("rst_pass_idx", 32'(pass_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sorted", 32'(sorted), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);
    reset = 1'b0;
    tick(2);

    // Reverse input: full 10-compare sort.
    load(50, 40, 30, 20, 10);
    base  = hs_count;
    dbase = done_cnt;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!cmp_valid && n < 100);
    check("first_req_latency", 32'(n), 32'd17);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done("rev_done");
    check("rev_handshakes", 32'(hs_count - base), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("rev_seq%0d", i), 32'(hs_log[base + i]), 32'(exp_seq[i]));
    check("rev_pass_idx", 32'(pass_idx), 32'd3);
    check("rev_swap_count", 32'(swap_count), 32'd10);
    check("rev_sorted", 32'(sorted), 32'd1);
    tick(3);
    check("rev_done_pulses", 32'(done_cnt - dbase), 32'd1);
    check("rev_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) check($sformatf("rev_arr%0d", i), 32'(arr[i]), 32'(10 * (i + 1)));

    // Already sorted: one pass, no swaps.
    load(10, 20, 30, 40, 50);
    base = hs_count;
    pulse_start();
    check("srt_sorted_cleared", 32'(sorted), 32'd0);
    wait_done("srt_done");
    check("srt_handshakes", 32'(hs_count - base), 32'd4);
    check("srt_swap_count", 32'(swap_count), 32'd0);
    check("srt_pass_idx", 32'(pass_idx), 32'd0);
    check("srt_sorted", 32'(sorted), 32'd1);

    // Pause / single-step / release.
    load(50, 40, 30, 20, 10);
    base = hs_count;
    pulse_start();
    wait_hs("pause_reach2", base + 2);
    pause = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmp_valid) seen = 1'b1;
    end
    check("pause_no_req", 32'(seen), 32'd0);
    check("pause_hs_held", 32'(hs_count - base), 32'd2);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    check("step1_one_hs", 32'(hs_count - base), 32'd3);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    check("step2_one_hs", 32'(hs_count - base), 32'd4);
    pause = 1'b0;
    wait_hs("resume_reach6", base + 6);
    check("resume_period", 32'(hs_cyc[base + 5] - hs_cyc[base + 4]), 32'd18);
    wait_done("pause_sort_done");
    check("pause_sort_swaps", 32'(swap_count), 32'd10);

    // Backpressure in ISSUE and a late response.
    ready_block = 1'b1;
    load(50, 40, 30, 20, 10);
    base = hs_count;
    pulse_start();
    n = 0;
    while (!cmp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_req_seen", 32'(cmp_valid), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!cmp_valid || cmp_idx != 3'd0) seen = 1'b1;
    end
    check("bp_req_stable", 32'(seen), 32'd0);
    resp_delay  = 7;
    ready_block = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmp_valid || !busy) seen = 1'b1;
    end
    check("late_resp_no_rereq", 32'(seen), 32'd0);
    check("late_resp_pending_count", 32'(swap_count), 32'd0);
    tick(1);
    check("late_resp_count", 32'(swap_count), 32'd1);
    check("late_resp_one_hs", 32'(hs_count - base), 32'd1);

    // Abort during RESP; the stale response must not count.
    resp_delay = 5;
    wait_hs("abort_reach_hs", base + 2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sorted", 32'(sorted), 32'd0);
    check("abort_cmp_valid", 32'(cmp_valid), 32'd0);
    tick(8);
    check("abort_swap_hold", 32'(swap_count), 32'd1);
    check("abort_cmp_idx_hold", 32'(cmp_idx), 32'd1);

    // Restart, then speed change mid-WAIT.
    resp_delay = 0;
    load(50, 40, 30, 20, 10);
    pulse_start();
    check("restart_swap_clear", 32'(swap_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    tick(10);
    check("speed_pre_no_req", 32'(cmp_valid), 32'd0);
    speed = 2'd3;
    tick(1);
    check("speed_fast_req", 32'(cmp_valid), 32'd1);
    check("speed_fast_idx", 32'(cmp_idx), 32'd0);
    tick(20);
    check("midsort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("mid_rst_cmp_idx", 32'(cmp_idx), 32'd0);
    check("mid_rst_pass_idx", 32'(pass_idx), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sorted", 32'(sorted), 32'd0);
    check("mid_rst_swap_count", 32'(swap_count), 32'd0);
    reset = 1'b0;
    speed = 2'd0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
